// File: rtl/up_bus_pkg.sv
// rtl/up_bus_pkg.sv - shared FSM encoding and defaults for the up-bus master
package up_bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [31:0] DEF_ERR_RDATA = 32'hDEADDEAD;
    localparam int          DEF_TIMEOUT_W = 8;

endpackage

// File: rtl/up_bus_master_if.sv
// rtl/up_bus_master_if.sv - command/response streams and up-bus signals of the up-bus master
interface up_bus_master_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    logic                  up_wreq;
    logic [ADDR_WIDTH-1:0] up_waddr;
    logic [31:0]           up_wdata;
    logic                  up_wack;
    logic                  up_rreq;
    logic [ADDR_WIDTH-1:0] up_raddr;
    logic [31:0]           up_rdata;
    logic                  up_rack;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready,
        input  up_wack, up_rdata, up_rack,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready,
        output up_wack, up_rdata, up_rack,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
    );
endinterface

// File: rtl/up_bus_timeout.sv
// rtl/up_bus_timeout.sv - ack-wait counter; expired flags the last allowed wait cycle
module up_bus_timeout
    import up_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = DEF_TIMEOUT_W
) (
    input  logic up_clk,
    input  logic up_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] cnt_q;

    // cnt_q counts completed wait cycles, so the N-th wait cycle is the expiring one
    assign expired = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/up_bus_master.sv
// rtl/up_bus_master.sv - single-command up-bus initiator; UP_BUS_MASTER_TIMEOUT_EN enables ack timeout
module up_bus_master
    import up_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 14,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
    input  logic            up_clk,
    input  logic            up_rst,
    up_bus_master_if.master bus
);
    logic [1:0]            state_q, state_d;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
    logic [31:0]           wdata_q, rdata_q;
    logic                  ack_match, expired, done;

    // only the ack of the bus actually in use can complete the transaction
    assign ack_match = wr_q ? bus.up_wack : bus.up_rack;
    assign done      = (state_q == ST_WAIT) && (ack_match || expired);

    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (ack_match || expired) state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.up_wreq   = 1'b0;
        bus.up_rreq   = 1'b0;
        case (state_q)
            ST_IDLE: bus.cmd_ready = 1'b1;
            ST_REQ:  begin
                bus.up_wreq = wr_q;
                bus.up_rreq = !wr_q;
            end
            ST_RESP: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // each bus keeps its last address/data; only the one being used is reloaded
    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == ST_IDLE && bus.cmd_valid) begin
                wr_q <= bus.cmd_wr;
                if (bus.cmd_wr) begin
                    waddr_q <= bus.cmd_addr;
                    wdata_q <= bus.cmd_wdata;
                end else begin
                    raddr_q <= bus.cmd_addr;
                end
            end
            if (done) begin
                if (wr_q)           rdata_q <= '0;
                else if (ack_match) rdata_q <= bus.up_rdata;
                else                rdata_q <= ERR_RDATA;
            end
        end
    end

    assign bus.up_waddr  = waddr_q;
    assign bus.up_wdata  = wdata_q;
    assign bus.up_raddr  = raddr_q;
    assign bus.rsp_rdata = rdata_q;

`ifdef UP_BUS_MASTER_TIMEOUT_EN
    logic err_q;

    up_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (DEF_TIMEOUT_W)
    ) u_timeout (
        .up_clk  (up_clk),
        .up_rst  (up_rst),
        .clr     (state_q == ST_REQ),
        .en      (state_q == ST_WAIT),
        .expired (expired)
    );

    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst)    err_q <= 1'b0;
        else if (done) err_q <= !ack_match;
    end

    assign bus.rsp_err = err_q;
`else
    logic unused_cfg;

    assign expired     = 1'b0;
    assign bus.rsp_err = 1'b0;
    assign unused_cfg  = ^TIMEOUT_CYCLES;
`endif
endmodule

// File: tb/tb_up_bus_master.sv
// tb/tb_up_bus_master.sv - directed scoreboard bench for up_bus_master
module tb_up_bus_master;
    localparam int TO = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    up_bus_master_if #(.ADDR_WIDTH(14)) bus ();

    up_bus_master #(
        .ADDR_WIDTH     (14),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (32'hDEADDEAD)
    ) dut (
        .up_clk (clk),
        .up_rst (rst),
        .bus    (bus.master)
    );

    rsp_t exp_q[$];
    int   checks = 0, passes = 0, fails = 0;
    int   exp_wreq = 0, exp_rreq = 0;
    int   wreq_cnt = 0, rreq_cnt = 0, both_cnt = 0;

    always @(negedge clk) begin
        if (bus.up_wreq) wreq_cnt++;
        if (bus.up_rreq) rreq_cnt++;
        if (bus.up_wreq && bus.up_rreq) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [13:0] addr, input logic [31:0] wdata,
                            input logic [31:0] erd, input logic eerr);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        exp_q.push_back('{rdata: erd, err: eerr});
        if (wr) exp_wreq++;
        else    exp_rreq++;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag);
        rsp_t e;
        int   n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
            chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bit bp_ok;
        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0; bus.up_wack = 1'b0; bus.up_rack = 1'b0; bus.up_rdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_reqs", {30'd0, bus.up_wreq, bus.up_rreq}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_waddr", {18'd0, bus.up_waddr}, 32'd0);

        // write, ack one cycle after the request
        send_cmd(1'b1, 14'h0010, 32'hA5A55A5A, 32'd0, 1'b0);
        chk("wr_wreq", {30'd0, bus.up_wreq, bus.up_rreq}, 32'd2);
        chk("wr_waddr", {18'd0, bus.up_waddr}, 32'h10);
        chk("wr_wdata", bus.up_wdata, 32'hA5A55A5A);
        tick();
        chk("wr_wreq_pulse", {31'd0, bus.up_wreq}, 32'd0);
        chk("wr_no_early_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        bus.up_wack = 1'b1;
        tick();
        bus.up_wack = 1'b0;
        chk("wr_latency", {31'd0, bus.rsp_valid}, 32'd1);
        get_rsp("wr");

        // read, ack three cycles after the request
        send_cmd(1'b0, 14'h0102, 32'd0, 32'h12345678, 1'b0);
        chk("rd_rreq", {30'd0, bus.up_wreq, bus.up_rreq}, 32'd1);
        chk("rd_raddr", {18'd0, bus.up_raddr}, 32'h102);
        chk("rd_waddr_kept", {18'd0, bus.up_waddr}, 32'h10);
        tick();
        tick();
        tick();
        chk("rd_wait", {31'd0, bus.rsp_valid}, 32'd0);
        bus.up_rack = 1'b1;
        bus.up_rdata = 32'h12345678;
        tick();
        bus.up_rack = 1'b0;
        bus.up_rdata = 32'h0;
        get_rsp("rd");

        // backpressure with a second command already waiting
        send_cmd(1'b1, 14'h0020, 32'h11112222, 32'd0, 1'b0);
        tick();
        bus.up_wack = 1'b1;
        tick();
        bus.up_wack = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 14'h0030; bus.cmd_wdata = '0;
        bp_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(bus.rsp_valid === 1'b1 && bus.rsp_rdata === 32'd0 && bus.rsp_err === 1'b0 &&
                  bus.cmd_ready === 1'b0 && bus.up_rreq === 1'b0)) bp_ok = 1'b0;
            tick();
        end
        chk("bp_stable", {31'd0, bp_ok}, 32'd1);
        chk("bp_no_issue", rreq_cnt, exp_rreq);
        get_rsp("bp_wr");
        chk("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        exp_q.push_back('{rdata: 32'h9ABCDEF0, err: 1'b0});
        exp_rreq++;
        tick();
        bus.cmd_valid = 1'b0;
        chk("bp_rd_issue", {30'd0, bus.up_wreq, bus.up_rreq}, 32'd1);
        chk("bp_raddr", {18'd0, bus.up_raddr}, 32'h30);
        tick();
        bus.up_rack = 1'b1;
        bus.up_rdata = 32'h9ABCDEF0;
        tick();
        bus.up_rack = 1'b0;
        get_rsp("bp_rd");

        // spurious and wrong-bus acks
        bus.up_wack = 1'b1;
        tick();
        bus.up_wack = 1'b0;
        tick();
        chk("spur_idle_wack", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
        send_cmd(1'b1, 14'h0040, 32'hCAFEF00D, 32'd0, 1'b0);
        tick();
        bus.up_rack = 1'b1;
        bus.up_rdata = 32'hFFFFFFFF;
        tick();
        bus.up_rack = 1'b0;
        chk("spur_rack_ignored", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        chk("spur_still_wait", {31'd0, bus.rsp_valid}, 32'd0);
        bus.up_wack = 1'b1;
        tick();
        bus.up_wack = 1'b0;
        get_rsp("spur_wr");
        bus.up_wack = 1'b1;
        tick();
        tick();
        bus.up_wack = 1'b0;
        tick();
        chk("spur_late_wack", {31'd0, bus.rsp_valid}, 32'd0);

`ifdef UP_BUS_MASTER_TIMEOUT_EN
        // unanswered read times out after TO wait cycles
        send_cmd(1'b0, 14'h0055, 32'd0, 32'hDEADDEAD, 1'b1);
        for (int i = 0; i < TO; i++) tick();
        chk("to_not_yet", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        chk("to_fires", {31'd0, bus.rsp_valid}, 32'd1);
        get_rsp("to_rd");
        // ack on the last allowed cycle wins
        send_cmd(1'b0, 14'h0056, 32'd0, 32'h0BADBEEF, 1'b0);
        for (int i = 0; i < TO; i++) tick();
        bus.up_rack = 1'b1;
        bus.up_rdata = 32'h0BADBEEF;
        tick();
        bus.up_rack = 1'b0;
        get_rsp("to_ack_wins");
        send_cmd(1'b1, 14'h0057, 32'h1, 32'd0, 1'b1);
        get_rsp("to_wr");
`endif

        // reset in the middle of a write
        send_cmd(1'b1, 14'h0077, 32'h5555AAAA, 32'd0, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_reqs", {30'd0, bus.up_wreq, bus.up_rreq}, 32'd0);
        chk("mid_rst_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("mid_rst_wdata", bus.up_wdata, 32'd0);
        exp_q.delete();
        tick();
        bus.up_wack = 1'b1;
        rst = 1'b0;
        tick();
        bus.up_wack = 1'b0;
        tick();
        chk("post_rst_idle", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
        send_cmd(1'b0, 14'h00AB, 32'd0, 32'h00C0FFEE, 1'b0);
        tick();
        bus.up_rack = 1'b1;
        bus.up_rdata = 32'h00C0FFEE;
        tick();
        bus.up_rack = 1'b0;
        get_rsp("post_rst_rd");

        tick();
        chk("wreq_count", wreq_cnt, exp_wreq);
        chk("rreq_count", rreq_cnt, exp_rreq);
        chk("req_overlap", both_cnt, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
